// File: rtl/ser_pkg.sv
// ser_pkg: shared definitions for the multi-lane serializer.
//   - ser_state_e      : FSM state encoding (IDLE, SOT, DATA, EOT)
//   - SYNC_WORD_DEFAULT: default start-of-transmission pattern
//   - clog2            : ceiling log2, usable in parameter/width expressions
package ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SOT  = 2'd1,
    ST_DATA = 2'd2,
    ST_EOT  = 2'd3
  } ser_state_e;

  localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hB8;

  // Returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/ser_sync_fifo.sv
// ser_sync_fifo: single-clock first-word-fall-through FIFO.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   push_i, wdata_i: write request / data (ignored while full)
//   pop_i          : read request (ignored while empty)
//   rdata_o        : head entry, valid whenever empty_o is low
//   full_o, empty_o, count_o: occupancy status
module ser_sync_fifo
  import ser_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [clog2(DEPTH):0] count_o
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
      else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ser_nlane_hs.sv
// ser_nlane_hs: parametrised multi-lane SDR serializer with burst framing.
// Ports:
//   TxSerClk, Tx_RST    : bit clock, asynchronous active-high reset
//   TxWordHS, TxValid, TxLast, TxReady : word input handshake into the FIFO
//   Serial[LANES-1:0]   : registered lane outputs
//   HsActive            : high during SOT, DATA and EOT
//   ErrUnderrun         : one-cycle pulse when the FIFO runs dry mid-burst
// Lane k carries word bits k, k+LANES, ... ; MSB_FIRST picks the send order.
module ser_nlane_hs
  import ser_pkg::*;
#(
  parameter int             W         = 8,
  parameter int             LANES     = 2,
  parameter int             DEPTH     = 4,
  parameter int             SYNC_EN   = 1,
  parameter logic [W-1:0]   SYNC_WORD = W'(SYNC_WORD_DEFAULT),
  parameter int             TRAIL_CYC = 4,
  parameter int             MSB_FIRST = 0
) (
  input  logic             TxSerClk,
  input  logic             Tx_RST,
  input  logic [W-1:0]     TxWordHS,
  input  logic             TxValid,
  input  logic             TxLast,
  output logic             TxReady,
  output logic [LANES-1:0] Serial,
  output logic             HsActive,
  output logic             ErrUnderrun
);

  localparam int BPL = W / LANES;
  localparam int BCW = clog2(BPL) + 1;
  localparam int TCW = clog2(TRAIL_CYC) + 1;
  localparam int FCW = clog2(DEPTH) + 1;

  // FIFO
  logic           fifo_push;
  logic [W:0]     fifo_rdata;
  logic           fifo_full;
  logic           fifo_empty;
  logic [FCW-1:0] fifo_count;

  // FSM state
  ser_state_e     state_q;
  logic [BCW-1:0] bit_cnt_q;
  logic [TCW-1:0] trail_cnt_q;
  logic           last_q;
  logic           hs_q;
  logic           err_q;

  // Decoded per-cycle actions
  logic           word_end;
  logic           trail_end;
  logic           load_sync;
  logic           load_fifo;
  logic           go_eot;
  logic           go_idle;
  logic           underrun;
  logic [W-1:0]   load_word;

  assign TxReady   = (fifo_count != FCW'(DEPTH));
  assign fifo_push = TxValid && !fifo_full;

  ser_sync_fifo #(
    .WIDTH (W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (TxSerClk),
    .rst_i   (Tx_RST),
    .push_i  (fifo_push),
    .wdata_i ({TxLast, TxWordHS}),
    .pop_i   (load_fifo),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    word_end  = (bit_cnt_q == BCW'(BPL - 1));
    trail_end = (trail_cnt_q == TCW'(TRAIL_CYC - 1));
    load_sync = 1'b0;
    load_fifo = 1'b0;
    go_eot    = 1'b0;
    go_idle   = 1'b0;
    underrun  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (SYNC_EN != 0) load_sync = 1'b1;
          else              load_fifo = 1'b1;
        end
      end
      // The burst-opening word stays in the FIFO through SOT, so it is present here.
      ST_SOT: if (word_end) load_fifo = 1'b1;
      ST_DATA: begin
        if (word_end) begin
          if (last_q)           go_eot = 1'b1;
          else if (!fifo_empty) load_fifo = 1'b1;
          else begin
            go_eot   = 1'b1;
            underrun = 1'b1;
          end
        end
      end
      ST_EOT:  if (trail_end) go_idle = 1'b1;
      default: ;
    endcase
  end

  assign load_word = load_sync ? SYNC_WORD : fifo_rdata[W-1:0];

  always_ff @(posedge TxSerClk or posedge Tx_RST) begin
    if (Tx_RST) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      trail_cnt_q <= '0;
      last_q      <= 1'b0;
      hs_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= underrun;
      if (load_sync || load_fifo) begin
        state_q     <= load_sync ? ST_SOT : ST_DATA;
        bit_cnt_q   <= '0;
        trail_cnt_q <= '0;
        hs_q        <= 1'b1;
        if (load_fifo) last_q <= fifo_rdata[W];
      end else if (go_eot) begin
        state_q     <= ST_EOT;
        bit_cnt_q   <= '0;
        trail_cnt_q <= '0;
      end else if (go_idle) begin
        state_q     <= ST_IDLE;
        bit_cnt_q   <= '0;
        trail_cnt_q <= '0;
        hs_q        <= 1'b0;
      end else if (state_q == ST_SOT || state_q == ST_DATA) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end else if (state_q == ST_EOT) begin
        trail_cnt_q <= trail_cnt_q + 1'b1;
      end
    end
  end

  assign HsActive    = hs_q;
  assign ErrUnderrun = err_q;

  // Per-lane shift register: index 0 of lane_bits is the first bit on the wire.
  // On a load the first bit goes straight to the output register and the
  // remainder waits in sh_q.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [BPL-1:0] lane_bits;
    logic [BPL-1:0] sh_q;
    logic           ser_q;

    for (genvar gj = 0; gj < BPL; gj++) begin : g_bit
      localparam int SRC = (MSB_FIRST != 0) ? gi + (BPL - 1 - gj) * LANES
                                            : gi + gj * LANES;
      assign lane_bits[gj] = load_word[SRC];
    end

    always_ff @(posedge TxSerClk or posedge Tx_RST) begin
      if (Tx_RST) begin
        sh_q  <= '0;
        ser_q <= 1'b0;
      end else if (load_sync || load_fifo) begin
        ser_q <= lane_bits[0];
        sh_q  <= lane_bits >> 1;
      end else if (go_eot) begin
        ser_q <= ~ser_q;           // trail: inverse of the last bit sent, held
      end else if (go_idle) begin
        ser_q <= 1'b0;
      end else if (state_q == ST_SOT || state_q == ST_DATA) begin
        ser_q <= sh_q[0];
        sh_q  <= sh_q >> 1;
      end
    end

    assign Serial[gi] = ser_q;
  end

endmodule

// File: tb/tb_ser_nlane_hs.sv
module tb_ser_nlane_hs;

  typedef struct packed {
    logic [3:0] ser;
    logic       err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  valid = '0;
  logic [2:0]  last  = '0;
  logic [2:0]  ready;
  logic [2:0]  hs;
  logic [2:0]  err;
  logic [7:0]  wa = '0;
  logic [7:0]  wb = '0;
  logic [15:0] wc = '0;
  logic [1:0]  ser_a;
  logic [1:0]  ser_b;
  logic [3:0]  ser_c;

  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t q [3][$];
  int   rises [3] = '{0, 0, 0};
  logic [2:0] hs_prev = '0;

  always #5 clk = ~clk;

  // d=0: default W=8/LANES=2; d=1: MSB_FIRST=1; d=2: W=16/LANES=4 without sync
  ser_nlane_hs #(.W(8), .LANES(2), .MSB_FIRST(0)) u_a (
    .TxSerClk(clk), .Tx_RST(rst), .TxWordHS(wa), .TxValid(valid[0]), .TxLast(last[0]),
    .TxReady(ready[0]), .Serial(ser_a), .HsActive(hs[0]), .ErrUnderrun(err[0]));
  ser_nlane_hs #(.W(8), .LANES(2), .MSB_FIRST(1)) u_b (
    .TxSerClk(clk), .Tx_RST(rst), .TxWordHS(wb), .TxValid(valid[1]), .TxLast(last[1]),
    .TxReady(ready[1]), .Serial(ser_b), .HsActive(hs[1]), .ErrUnderrun(err[1]));
  ser_nlane_hs #(.W(16), .LANES(4), .SYNC_EN(0), .SYNC_WORD(16'h00B8)) u_c (
    .TxSerClk(clk), .Tx_RST(rst), .TxWordHS(wc), .TxValid(valid[2]), .TxLast(last[2]),
    .TxReady(ready[2]), .Serial(ser_c), .HsActive(hs[2]), .ErrUnderrun(err[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int nl(input int d);
    return (d == 2) ? 4 : 2;
  endfunction

  function automatic logic [3:0] lmask(input int d);
    return (d == 2) ? 4'hF : 4'h3;
  endfunction

  // Lane vector on the wire at step j (0..3) of word w, from the lane mapping rule.
  function automatic logic [3:0] lbits(input int d, input logic [15:0] w, input int j);
    logic [3:0] r;
    int idx;
    r = '0;
    for (int k = 0; k < nl(d); k++) begin
      idx  = (d == 1) ? k + (3 - j) * nl(d) : k + j * nl(d);
      r[k] = w[idx];
    end
    return r;
  endfunction

  function automatic logic [3:0] getser(input int d);
    case (d)
      0:       return {2'b00, ser_a};
      1:       return {2'b00, ser_b};
      default: return ser_c;
    endcase
  endfunction

  task automatic exp_add(input int d, input logic [3:0] s, input logic e);
    exp_t x;
    x.ser = s;
    x.err = e;
    q[d].push_back(x);
  endtask

  // Queue the expected wire activity for one word, then push it through the handshake.
  task automatic send(input int d, input logic [15:0] w, input bit first, input bit fin, input bit lst);
    int t;
    if (first && d != 2)
      for (int j = 0; j < 4; j++) exp_add(d, lbits(d, 16'h00B8, j), 1'b0);
    for (int j = 0; j < 4; j++) exp_add(d, lbits(d, w, j), 1'b0);
    if (fin)
      for (int j = 0; j < 4; j++) exp_add(d, ~lbits(d, w, 3) & lmask(d), (j == 0) && !lst);
    @(negedge clk);
    case (d)
      0:       wa = w[7:0];
      1:       wb = w[7:0];
      default: wc = w;
    endcase
    valid[d] = 1'b1;
    last[d]  = lst;
    t = 0;
    while (!ready[d] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    valid[d] = 1'b0;
    last[d]  = 1'b0;
  endtask

  task automatic drain(input int d, input int nr);
    int t;
    t = 0;
    while ((q[d].size() != 0 || hs[d]) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("drain_left_d%0d", d), q[d].size(), 0);
    check($sformatf("drain_hs_d%0d", d), hs[d], 1'b0);
    check($sformatf("burst_count_d%0d", d), rises[d], nr);
    rises[d] = 0;
  endtask

  // Monitor: every active cycle pops one expected lane vector; idle cycles must be quiet.
  always @(negedge clk) begin
    exp_t x;
    for (int d = 0; d < 3; d++) begin
      if (hs[d] && !hs_prev[d]) rises[d]++;
      if (hs[d]) begin
        if (q[d].size() == 0) begin
          check($sformatf("unexpected_hs_d%0d", d), {29'd0, getser(d) == 4'd0 ? 3'd1 : 3'd2}, 32'd0);
        end else begin
          x = q[d].pop_front();
          check($sformatf("serial_d%0d", d), getser(d), x.ser);
          check($sformatf("underrun_d%0d", d), err[d], x.err);
        end
      end else begin
        check($sformatf("idle_serial_d%0d", d), getser(d), 4'd0);
        check($sformatf("idle_err_d%0d", d), err[d], 1'b0);
      end
    end
    hs_prev = hs;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required self-termination");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_hs", hs, 3'b000);
    check("rst_err", err, 3'b000);
    check("rst_ser_a", ser_a, 2'b00);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", ready, 3'b111);

    // single word with sync, LSB-first lanes
    send(0, 16'h00AB, 1, 1, 1);
    drain(0, 1);

    // same word, MSB-first lanes
    send(1, 16'h00AB, 1, 1, 1);
    drain(1, 1);

    // six-word burst through a four-deep FIFO
    for (int i = 0; i < 6; i++) begin
      send(0, 16'(i), i == 0, i == 5, i == 5);
      if (i == 2) check("ready_at_3", ready[0], 1'b1);
      if (i == 3) check("ready_at_4", ready[0], 1'b0);
    end
    drain(0, 1);

    // underrun: no word carries Last and the FIFO runs dry after word 2
    send(0, 16'h005A, 1, 0, 0);
    send(0, 16'h00C3, 0, 0, 0);
    send(0, 16'h003C, 0, 1, 0);
    drain(0, 1);

    // reset in the middle of DATA
    send(0, 16'h0011, 1, 0, 0);
    send(0, 16'h0022, 0, 0, 0);
    send(0, 16'h0033, 0, 1, 1);
    repeat (5) @(negedge clk);
    check("pre_rst_active", hs[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_hs", hs[0], 1'b0);
    check("async_rst_ser", ser_a, 2'b00);
    q[0].delete();
    rises[0] = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_post_rst", ready[0], 1'b1);
    repeat (6) @(negedge clk);
    check("fifo_flushed_hs", hs[0], 1'b0);
    check("fifo_flushed_bursts", rises[0], 0);
    send(0, 16'h00AB, 1, 1, 1);
    drain(0, 1);

    // 16-bit word across four lanes, no sync
    send(2, 16'h8421, 1, 1, 1);
    drain(2, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
